// File: rtl/interrupt_controller.sv
// interrupt_controller: eight-source prioritised interrupt controller with a
// four-byte CPU register window (PENDING, ENABLE, CONTROL, STATUS) and a
// three-state request/service handshake towards the CPU.
//
// Build option: define INTERRUPT_CONTROLLER_EDGE_DETECT_EN to treat a 0->1
// transition of irq_in as the set event (held-high inputs set PENDING once).
// Without it, every cycle with irq_in[i]=1 is a set event.
module interrupt_controller #(
    parameter logic [7:0] INTERRUPT_CONTROLLER_ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] irq_in,
    input  logic       int_ack,
    input  logic       reti,
    output logic       irq,
    output logic [2:0] vector
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRequest = 2'd1,
        StService = 2'd2
    } state_e;

    localparam logic [1:0] RegPending = 2'd0;
    localparam logic [1:0] RegEnable  = 2'd1;
    localparam logic [1:0] RegControl = 2'd2;
    localparam logic [1:0] RegStatus  = 2'd3;

    // Register window decode
    logic [7:0] offset;
    logic       mapped;
    logic [1:0] reg_sel;
    logic       wr_pending;
    logic       wr_enable;
    logic       wr_control;

    // Architectural state
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] enable_q;
    logic       control_q;
    state_e     state_q;

    // Pending-bit update terms
    logic [7:0] set_event;
    logic [7:0] ack_mask;
    logic [7:0] clear_mask;
    logic       ack_fire;

    // Arbitration
    logic [7:0] active;
    logic       win_valid;
    logic [2:0] win_idx;
    logic       cancel;

    // Read path
    logic       in_service;
    logic [7:0] status;
    logic [7:0] rd_data;

    // Subtracting the base lets a window that straddles 8'hFF still decode.
    assign offset  = address - INTERRUPT_CONTROLLER_ADDRESS;
    assign mapped  = (offset[7:2] == 6'd0);
    assign reg_sel = offset[1:0];

    assign wr_pending = w_en && mapped && (reg_sel == RegPending);
    assign wr_enable  = w_en && mapped && (reg_sel == RegEnable);
    assign wr_control = w_en && mapped && (reg_sel == RegControl);

`ifdef INTERRUPT_CONTROLLER_EDGE_DETECT_EN
    logic [7:0] irq_hist_q;

    // Previous-cycle copy of irq_in for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_hist_q <= 8'h00;
        end else begin
            irq_hist_q <= irq_in;
        end
    end

    assign set_event = irq_in & ~irq_hist_q;
`else
    assign set_event = irq_in;
`endif

    // The acknowledge only clears a bit while a request is actually outstanding.
    assign ack_fire   = (state_q == StRequest) && int_ack;
    assign ack_mask   = ack_fire ? (8'h01 << vector) : 8'h00;
    assign clear_mask = (wr_pending ? din : 8'h00) | ack_mask;

    // Set is OR-ed in after clearing so a coincident set event always wins.
    assign pending_d = (pending_q & ~clear_mask) | set_event;

    assign active = pending_q & enable_q;

    // Fixed priority: the lowest active index wins
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    // An outstanding request is withdrawn if its source can no longer be serviced.
    assign cancel = !pending_q[vector] || !enable_q[vector] || !control_q;

    assign in_service = (state_q == StService);
    assign status     = {in_service, 4'b0000, vector};

    // Register read multiplexer
    always_comb begin
        rd_data = 8'h00;
        unique case (reg_sel)
            RegPending: rd_data = pending_q;
            RegEnable:  rd_data = enable_q;
            RegControl: rd_data = {7'b0000000, control_q};
            RegStatus:  rd_data = status;
            default:    rd_data = 8'h00;
        endcase
    end

    // PENDING register: source set events and CPU/acknowledge clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 8'h00;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ENABLE and CONTROL registers written by the CPU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= 8'h00;
            control_q <= 1'b0;
        end else begin
            if (wr_enable) begin
                enable_q <= din;
            end
            if (wr_control) begin
                control_q <= din[0];
            end
        end
    end

    // Registered read data: loads on a mapped read, zeroes on unmapped addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 8'h00;
        end else if (!mapped) begin
            dout <= 8'h00;
        end else if (r_en) begin
            dout <= rd_data;
        end
    end

    // Request/service handshake FSM with registered irq and vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            irq     <= 1'b0;
            vector  <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (control_q && win_valid) begin
                        state_q <= StRequest;
                        irq     <= 1'b1;
                        vector  <= win_idx;
                    end
                end
                StRequest: begin
                    // Priority is frozen here; later arrivals wait for the next idle.
                    if (int_ack) begin
                        state_q <= StService;
                        irq     <= 1'b0;
                    end else if (cancel) begin
                        state_q <= StIdle;
                        irq     <= 1'b0;
                    end
                end
                StService: begin
                    if (reti) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    irq     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table, hand-written corner-case
// sequences and a randomized run against a behavioural model.
module tb_interrupt_controller;

    localparam logic [7:0] BASE   = 8'h40;
    localparam logic [7:0] A_PEND = BASE;
    localparam logic [7:0] A_EN   = BASE + 8'd1;
    localparam logic [7:0] A_CTL  = BASE + 8'd2;
    localparam logic [7:0] A_STAT = BASE + 8'd3;
    localparam logic [7:0] A_UNM  = BASE + 8'd4;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] irq_in;
    logic       int_ack;
    logic       reti;
    logic       irq;
    logic [2:0] vector;

    int checks   = 0;
    int failures = 0;

    interrupt_controller #(
        .INTERRUPT_CONTROLLER_ADDRESS(BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .address(address),
        .w_en   (w_en),
        .r_en   (r_en),
        .dout   (dout),
        .irq_in (irq_in),
        .int_ack(int_ack),
        .reti   (reti),
        .irq    (irq),
        .vector (vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] addr;
        logic       w_en;
        logic       r_en;
        logic [7:0] irq_in;
        logic       ack;
        logic       reti;
        logic [7:0] e_dout;
        logic       e_irq;
        logic [2:0] e_vec;
    } row_t;

    row_t tbl[$];

    // Behavioural model: mode 0 idle, 1 requesting, 2 in service
    logic       model_on = 1'b0;
    logic [7:0] m_pend, m_en, m_dout, m_hist;
    logic       m_ctl;
    logic [2:0] m_vec;
    int         m_mode;

    function automatic row_t mk(logic [7:0] d, logic [7:0] a, logic w, logic r, logic [7:0] s,
                                logic k, logic t, logic [7:0] ed, logic ei, logic [2:0] ev);
        row_t x;
        x.din = d; x.addr = a; x.w_en = w; x.r_en = r; x.irq_in = s;
        x.ack = k; x.reti = t; x.e_dout = ed; x.e_irq = ei; x.e_vec = ev;
        return x;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h expected=%02h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [7:0] a, input logic w, input logic r,
                         input logic [7:0] s, input logic k, input logic t);
        din = d; address = a; w_en = w; r_en = r; irq_in = s; int_ack = k; reti = t;
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_en = 8'h00; m_ctl = 1'b0; m_dout = 8'h00;
        m_vec = 3'd0; m_mode = 0; m_hist = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] set_ev, clr, off, rd, pend_n;
        int         win;
`ifdef INTERRUPT_CONTROLLER_EDGE_DETECT_EN
        set_ev = irq_in & ~m_hist;
`else
        set_ev = irq_in;
`endif
        m_hist = irq_in;
        off = address - BASE;
        case (off)
            8'd0:    rd = m_pend;
            8'd1:    rd = m_en;
            8'd2:    rd = {7'd0, m_ctl};
            default: rd = {(m_mode == 2), 4'd0, m_vec};
        endcase
        win = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i] && win < 0) win = i;
        end
        clr = (w_en && off == 8'd0) ? din : 8'h00;
        if (int_ack && m_mode == 1) clr[m_vec] = 1'b1;
        pend_n = (m_pend & ~clr) | set_ev;
        case (m_mode)
            0: if (m_ctl && win >= 0) begin m_mode = 1; m_vec = 3'(win); end
            1: if (int_ack) m_mode = 2;
               else if (!m_pend[m_vec] || !m_en[m_vec] || !m_ctl) m_mode = 0;
            default: if (reti) m_mode = 0;
        endcase
        if (off >= 8'd4) m_dout = 8'h00;
        else if (r_en) m_dout = rd;
        if (w_en && off == 8'd1) m_en = din;
        if (w_en && off == 8'd2) m_ctl = din[0];
        m_pend = pend_n;
    endtask

    // One clock: model advances on the edge, outputs settle by the #1
    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
    endtask

    initial begin
        logic [7:0] exp37;
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset.dout", dout, 8'h00);
        check("reset.irq", {7'd0, irq}, 8'h00);
        check("reset.vector", {5'd0, vector}, 8'h00);
        tick();
        tick();
        rst = 1'b1;

        // din, addr, w, r, irq_in, ack, reti, exp dout, exp irq, exp vector
        tbl.push_back(mk(8'h01, A_EN,   1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, A_CTL,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h01, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h01, 1, 0));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 0, 0, 8'h80, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h06, A_EN,   1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h06, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h06, 1, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 1, 0, 8'h06, 0, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 1, 8'h06, 0, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h06, 1, 2));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 1, 0, 8'h06, 0, 2));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 1, 8'h06, 0, 2));
        tbl.push_back(mk(8'h08, A_EN,   1, 0, 8'h00, 0, 0, 8'h06, 0, 2));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h08, 0, 0, 8'h06, 0, 2));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h06, 1, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 1, 0, 8'h08, 0, 3));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 0, 0, 8'h83, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 0, 1, 8'h83, 0, 3));
        tbl.push_back(mk(8'h00, A_STAT, 0, 1, 8'h00, 0, 0, 8'h03, 0, 3));
        tbl.push_back(mk(8'h00, A_EN,   1, 0, 8'h00, 0, 0, 8'h03, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h04, 0, 0, 8'h03, 0, 3));
        tbl.push_back(mk(8'h04, A_PEND, 1, 0, 8'h04, 0, 0, 8'h03, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h04, 0, 3));
        tbl.push_back(mk(8'h04, A_PEND, 1, 0, 8'h00, 0, 0, 8'h04, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(8'h00, A_CTL,  0, 1, 8'h00, 0, 0, 8'h01, 0, 3));
        tbl.push_back(mk(8'h00, A_UNM,  0, 0, 8'h00, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(8'h01, A_EN,   1, 0, 8'h00, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h01, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'h01, A_PEND, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h02, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 1, 0, 8'h02, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 1, 8'h00, 0, 0, 8'h02, 0, 0));
        tbl.push_back(mk(8'h03, A_EN,   1, 0, 8'h00, 0, 0, 8'h02, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h02, 1, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h01, 0, 0, 8'h02, 1, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h02, 1, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 1, 0, 8'h02, 0, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 1, 8'h02, 0, 1));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 0, 8'h02, 1, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 1, 0, 8'h02, 0, 0));
        tbl.push_back(mk(8'h00, A_PEND, 0, 0, 8'h00, 0, 1, 8'h02, 0, 0));

        foreach (tbl[n]) begin
            drive(tbl[n].din, tbl[n].addr, tbl[n].w_en, tbl[n].r_en, tbl[n].irq_in,
                  tbl[n].ack, tbl[n].reti);
            tick();
            check($sformatf("row%0d.dout", n), dout, tbl[n].e_dout);
            check($sformatf("row%0d.irq", n), {7'd0, irq}, {7'd0, tbl[n].e_irq});
            check($sformatf("row%0d.vector", n), {5'd0, vector}, {5'd0, tbl[n].e_vec});
        end

        // irq_in[4] held high for 10 cycles with a W1C on cycle 3
        drive(8'h00, A_EN, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
`ifdef INTERRUPT_CONTROLLER_EDGE_DETECT_EN
        exp37 = 8'h00;
`else
        exp37 = 8'h10;
`endif
        for (int c = 0; c < 10; c++) begin
            drive((c == 3) ? 8'h10 : 8'h00, A_PEND, (c == 3), 1'b1, 8'h10, 1'b0, 1'b0);
            tick();
            if (c == 1) check("held.before_w1c", dout, 8'h10);
            if (c == 4) check("held.after_w1c", dout, exp37);
            if (c == 5) check("held.next", dout, exp37);
        end
        drive(8'hFF, A_PEND, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a service
        drive(8'h08, A_EN, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
        tick();
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("mid.irq", {7'd0, irq}, 8'h01);
        check("mid.vector", {5'd0, vector}, 8'h03);
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(8'h00, A_STAT, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        check("mid.status", dout, 8'h83);
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("async_rst.dout", dout, 8'h00);
        check("async_rst.irq", {7'd0, irq}, 8'h00);
        check("async_rst.vector", {5'd0, vector}, 8'h00);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(8'h00, BASE + 8'(k), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            tick();
            check($sformatf("post_rst.reg%0d", k), dout, 8'h00);
            check($sformatf("post_rst.irq%0d", k), {7'd0, irq}, 8'h00);
        end

        // Randomized run against the model
        drive(8'h00, A_PEND, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        model_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            int         r;
            r = $urandom_range(0, 9);
            a = (r < 8) ? BASE + 8'(r % 4) : 8'($urandom);
            drive(8'($urandom), a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            tick();
            check($sformatf("rand%0d.dout", n), dout, m_dout);
            check($sformatf("rand%0d.irq", n), {7'd0, irq}, {7'd0, (m_mode == 1)});
            check($sformatf("rand%0d.vector", n), {5'd0, vector}, {5'd0, m_vec});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
